// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared control types and constants for the CPU sequencer
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    COND_Z0 = 2'b00,
    COND_Z1 = 2'b01,
    COND_S1 = 2'b10,
    COND_AL = 2'b11
  } cond_e;

  localparam logic [3:0] CMP_OP_DEF  = 4'b1001;
  localparam logic [3:0] HALT_OP_DEF = 4'b1111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 2;

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - control bus between sequencer and CPU datapath
interface cpu_sequencer_if #(
  parameter int PC_W = 3
);
  logic            run;
  logic            step_req;
  logic [1:0]      cond;
  logic [3:0]      opcode;
  logic [3:0]      flags;
  logic [PC_W-1:0] pc;
  logic            rom_oeb;
  logic            rf_ce;
  logic            rf_rw;
  logic            alu_execute;
  logic            step_done;
  logic            halted;

  modport master (
    input  run, step_req, cond, opcode, flags,
    output pc, rom_oeb, rf_ce, rf_rw, alu_execute, step_done, halted
  );

  modport slave (
    output run, step_req, cond, opcode, flags,
    input  pc, rom_oeb, rf_ce, rf_rw, alu_execute, step_done, halted
  );
endinterface

// File: rtl/cpu_sequencer_cond_check.sv
// rtl/cpu_sequencer_cond_check.sv - conditional-execution test against latched ALU flags
module cond_check
  import cpu_ctrl_pkg::*;
(
  input  logic [1:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       exec_o
);

  logic unused_flags;
  assign unused_flags = ^{flags_i[3], flags_i[1]};

  always_comb begin
    exec_o = 1'b0;
    case (cond_i)
      COND_Z0: exec_o = ~flags_i[FLAG_Z];
      COND_Z1: exec_o =  flags_i[FLAG_Z];
      COND_S1: exec_o =  flags_i[FLAG_S];
      COND_AL: exec_o = 1'b1;
      default: exec_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute/writeback sequencer with run, step and halt control
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int         PC_W    = 3,
  parameter logic [3:0] CMP_OP  = CMP_OP_DEF,
  parameter logic [3:0] HALT_OP = HALT_OP_DEF
) (
  input  logic             clock,
  input  logic             reset,
  cpu_sequencer_if.master  bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      flags_q, flags_d;
  logic            exec_q, exec_d;
  logic            cond_exec;

  logic rom_oeb, rf_ce, rf_rw, alu_execute, step_done, halted;

  cond_check u_cond_check (
    .cond_i  (bus.cond),
    .flags_i (flags_q),
    .exec_o  (cond_exec)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      flags_q <= '0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      exec_q  <= exec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flags_d     = flags_q;
    exec_d      = exec_q;
    rom_oeb     = 1'b0;
    rf_ce       = 1'b0;
    rf_rw       = 1'b1;
    alu_execute = 1'b0;
    step_done   = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.run || bus.step_req) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        rom_oeb = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        rf_ce   = 1'b1;
        exec_d  = cond_exec;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        rf_ce       = 1'b1;
        alu_execute = exec_q;
        state_d     = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        // Compares update flags but never write the register bank.
        alu_execute = exec_q;
        rf_ce       = exec_q;
        rf_rw       = ~(exec_q && (bus.opcode != CMP_OP));
        step_done   = 1'b1;
        pc_d        = pc_q + 1'b1;
        if (exec_q) flags_d = bus.flags;
        if (exec_q && (bus.opcode == HALT_OP)) state_d = ST_HALT;
        else if (bus.run)                      state_d = ST_FETCH;
        else                                   state_d = ST_IDLE;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.rom_oeb     = rom_oeb;
  assign bus.rf_ce       = rf_ce;
  assign bus.rf_rw       = rf_rw;
  assign bus.alu_execute = alu_execute;
  assign bus.step_done   = step_done;
  assign bus.halted      = halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer against an instruction-level model
module tb_cpu_sequencer;

  localparam int         PC_W    = 3;
  localparam logic [3:0] CMP_OP  = 4'b1001;
  localparam logic [3:0] HALT_OP = 4'b1111;

  logic clock = 1'b0;
  logic reset;

  cpu_sequencer_if #(.PC_W(PC_W)) bus ();

  cpu_sequencer #(.PC_W(PC_W), .CMP_OP(CMP_OP), .HALT_OP(HALT_OP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errs    = 0;

  int         m_pc;
  logic [3:0] m_flags;
  bit         m_halted;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [1:0] c, input logic [3:0] f);
    case (c)
      2'b00:   return !f[0];
      2'b01:   return f[0];
      2'b10:   return f[2];
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc     = 0;
    m_flags  = 4'h0;
    m_halted = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".rom_oeb"}, bus.rom_oeb, 0);
    chk({tag, ".rf_ce"}, bus.rf_ce, 0);
    chk({tag, ".rf_rw"}, bus.rf_rw, 1);
    chk({tag, ".alu"}, bus.alu_execute, 0);
    chk({tag, ".step_done"}, bus.step_done, 0);
    chk({tag, ".halted"}, bus.halted, m_halted);
    chk({tag, ".pc"}, bus.pc, m_pc[PC_W-1:0]);
  endtask

  // Entered at the negedge where the DUT sits in FETCH; returns one negedge after WRITEBACK.
  task automatic do_instr(input logic [1:0] c, input logic [3:0] op, input logic [3:0] fl);
    bit e;
    e = cond_ok(c, m_flags);
    chk("fetch.rom_oeb", bus.rom_oeb, 1);
    chk("fetch.rf_ce", bus.rf_ce, 0);
    chk("fetch.pc", bus.pc, m_pc[PC_W-1:0]);
    bus.cond = c; bus.opcode = op; bus.flags = fl;
    @(negedge clock);
    chk("decode.rom_oeb", bus.rom_oeb, 0);
    chk("decode.rf_ce", bus.rf_ce, 1);
    chk("decode.rf_rw", bus.rf_rw, 1);
    chk("decode.alu", bus.alu_execute, 0);
    @(negedge clock);
    chk("exec.rf_ce", bus.rf_ce, 1);
    chk("exec.rf_rw", bus.rf_rw, 1);
    chk("exec.alu", bus.alu_execute, e);
    chk("exec.step_done", bus.step_done, 0);
    @(negedge clock);
    chk("wb.alu", bus.alu_execute, e);
    chk("wb.rf_ce", bus.rf_ce, e);
    chk("wb.rf_rw", bus.rf_rw, (e && op != CMP_OP) ? 0 : 1);
    chk("wb.step_done", bus.step_done, 1);
    chk("wb.pc", bus.pc, m_pc[PC_W-1:0]);
    if (e) m_flags = fl;
    m_pc = (m_pc + 1) % (1 << PC_W);
    if (e && op == HALT_OP) m_halted = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_quiet(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bus.run = 1'b0; bus.step_req = 1'b0;
    bus.cond = 2'b11; bus.opcode = 4'h0; bus.flags = 4'h0;
    model_reset();
    reset = 1'b1;
    @(negedge clock);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clock);
    check_quiet("idle0");

    // Free-run, always-execute, pc wraps after 8 instructions.
    bus.run = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 8; i++)
      do_instr(2'b11, 4'($urandom_range(0, 8)), 4'($urandom));
    chk("wrap.pc", bus.pc, 0);

    do_instr(2'b11, CMP_OP, 4'b0001);
    do_instr(2'b00, 4'h3, 4'b0000);
    do_instr(2'b01, 4'h4, 4'b0100);
    do_instr(2'b10, 4'h5, 4'($urandom));

    for (int i = 0; i < 24; i++)
      do_instr(2'($urandom), 4'($urandom_range(0, 14)), 4'($urandom));

    // run drops during FETCH: instruction completes, then IDLE.
    bus.run = 1'b0;
    do_instr(2'b11, 4'h2, 4'($urandom));
    check_quiet("run_fall.idle");

    pulse_reset("rst_step");
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 10; j++) begin
        @(negedge clock);
        check_quiet("step.idle");
      end
      bus.step_req = 1'b1;
      @(negedge clock);
      bus.step_req = 1'b0;
      do_instr(2'($urandom), 4'($urandom_range(0, 14)), 4'($urandom));
    end
    chk("step.pc3", bus.pc, 3);
    check_quiet("step.end");

    // HALT at pc=5.
    pulse_reset("rst_halt");
    bus.run = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 5; i++)
      do_instr(2'b11, 4'($urandom_range(0, 14)), 4'($urandom));
    do_instr(2'b11, HALT_OP, 4'($urandom));
    chk("halt.halted", bus.halted, 1);
    chk("halt.pc6", bus.pc, 6);
    for (int i = 0; i < 8; i++) begin
      bus.run = 1'($urandom); bus.step_req = 1'($urandom);
      @(negedge clock);
      check_quiet("halt.frozen");
    end
    bus.run = 1'b0; bus.step_req = 1'b0;
    pulse_reset("rst_unhalt");
    chk("unhalt.halted", bus.halted, 0);

    // Reset asserted during EXECUTE of a writing instruction.
    bus.run = 1'b1;
    @(negedge clock);
    bus.cond = 2'b11; bus.opcode = 4'h2;
    @(negedge clock);
    @(negedge clock);
    chk("midrst.exec_alu", bus.alu_execute, 1);
    reset = 1'b1;
    #1;
    check_quiet("midrst.async");
    @(posedge clock);
    #1;
    chk("midrst.no_write", bus.rf_rw, 1);
    @(negedge clock);
    bus.run = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check_quiet("midrst.idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
